// File: rtl/blockram_arb_pkg.sv
// Shared types for the SD buffer block RAM arbiter.
// States, owner codes, read-tag bundle.
package blockram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN_A = 2'd1,
    ST_OWN_B = 2'd2
  } arb_state_e;

  localparam logic [1:0] OWNER_NONE = 2'b00;
  localparam logic [1:0] OWNER_A    = 2'b01;
  localparam logic [1:0] OWNER_B    = 2'b10;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  typedef struct packed {
    logic valid;
    logic port;
  } rtag_t;

  function automatic arb_state_e own_state(input logic port);
    return (port == PORT_A) ? ST_OWN_A : ST_OWN_B;
  endfunction

endpackage

// File: rtl/blockram_arb_rtag.sv
// Read-tag delay line: carries {valid, port} of each accepted read
// to the cycle its RAM data appears. Ports: clk_i, areset_n_i, push_i, port_i, rvalid_a_o, rvalid_b_o.
module blockram_arb_rtag
  import blockram_arb_pkg::*;
#(
  parameter int RD_LAT = 2
) (
  input  logic clk_i,
  input  logic areset_n_i,
  input  logic push_i,
  input  logic port_i,
  output logic rvalid_a_o,
  output logic rvalid_b_o
);

  rtag_t line_q [RD_LAT];
  rtag_t tail;

  always_ff @(posedge clk_i or negedge areset_n_i) begin
    if (!areset_n_i) begin
      for (int i = 0; i < RD_LAT; i++) begin
        line_q[i] <= '0;
      end
    end else begin
      line_q[0] <= rtag_t'{valid: push_i, port: port_i};
      for (int i = 1; i < RD_LAT; i++) begin
        line_q[i] <= line_q[i-1];
      end
    end
  end

  assign tail       = line_q[RD_LAT-1];
  assign rvalid_a_o = tail.valid & (tail.port == PORT_A);
  assign rvalid_b_o = tail.valid & (tail.port == PORT_B);

endmodule

// File: rtl/blockram_arbiter.sv
// Round-robin two-port arbiter for the SD buffer block RAM (A=spooler, B=DMA).
// Ports: per-port req/lock/we/addr/wdata in, ack/rdata/rvalid out; registered RAM pins; owner_o.
module blockram_arbiter
  import blockram_arb_pkg::*;
#(
  parameter int AW        = 16,
  parameter int DW        = 8,
  parameter int RD_LAT    = 2,
  parameter int BURST_MAX = 16
) (
  input  logic          clk_i,
  input  logic          areset_n_i,
  input  logic          req_a_i,
  input  logic          req_b_i,
  input  logic          lock_a_i,
  input  logic          lock_b_i,
  input  logic          we_a_i,
  input  logic          we_b_i,
  input  logic [AW-1:0] addr_a_i,
  input  logic [AW-1:0] addr_b_i,
  input  logic [DW-1:0] wdata_a_i,
  input  logic [DW-1:0] wdata_b_i,
  output logic          ack_a_o,
  output logic          ack_b_o,
  output logic [DW-1:0] rdata_a_o,
  output logic [DW-1:0] rdata_b_o,
  output logic          rvalid_a_o,
  output logic          rvalid_b_o,
  output logic [AW-1:0] ram_address_o,
  output logic [DW-1:0] ram_data_o,
  output logic          ram_wren_o,
  input  logic [DW-1:0] ram_q_i,
  output logic [1:0]    owner_o
);

  localparam int BCW = $clog2(BURST_MAX + 1);
  localparam logic [BCW-1:0] CNT_LAST = BCW'(BURST_MAX - 1);

  arb_state_e     state;
  logic           last_served;
  logic [BCW-1:0] burst_cnt;

  logic          own_a;
  logic          own_b;
  logic          cur_port;
  logic          cur_lock;
  logic          cur_we;
  logic          oth_req;
  logic [AW-1:0] cur_addr;
  logic [DW-1:0] cur_wdata;
  logic          accept;
  logic          cnt_last;
  logic          release_now;
  logic          switch_now;
  logic          keep_burst;
  logic          idle_win_b;

  assign own_a = (state == ST_OWN_A);
  assign own_b = (state == ST_OWN_B);

  assign ack_a_o = own_a & req_a_i & areset_n_i;
  assign ack_b_o = own_b & req_b_i & areset_n_i;
  assign accept  = ack_a_o | ack_b_o;

  always_comb begin
    cur_port  = own_b ? PORT_B : PORT_A;
    cur_lock  = own_b ? lock_b_i : lock_a_i;
    cur_we    = own_b ? we_b_i : we_a_i;
    cur_addr  = own_b ? addr_b_i : addr_a_i;
    cur_wdata = own_b ? wdata_b_i : wdata_a_i;
    oth_req   = own_b ? req_a_i : req_b_i;
  end

  // Burst ends on an unlocked accept, or when the cap is hit while the
  // other side waits. A non-accepting owner always hands over if it can.
  assign cnt_last    = (burst_cnt == CNT_LAST);
  assign release_now = ~cur_lock | (cnt_last & oth_req);
  assign switch_now  = oth_req & (~accept | release_now);
  assign keep_burst  = accept & ~release_now;

  // Tie from IDLE goes to whichever port was not served last.
  assign idle_win_b = req_b_i & (~req_a_i | (last_served == PORT_A));

  always_ff @(posedge clk_i or negedge areset_n_i) begin
    if (!areset_n_i) begin
      state         <= ST_IDLE;
      last_served   <= PORT_B;
      burst_cnt     <= '0;
      ram_address_o <= '0;
      ram_data_o    <= '0;
      ram_wren_o    <= 1'b0;
    end else begin
      ram_wren_o <= 1'b0;
      if (state == ST_IDLE) begin
        burst_cnt <= '0;
        if (idle_win_b) begin
          state <= ST_OWN_B;
        end else if (req_a_i) begin
          state <= ST_OWN_A;
        end
      end else begin
        if (accept) begin
          ram_address_o <= cur_addr;
          ram_data_o    <= cur_wdata;
          ram_wren_o    <= cur_we;
        end
        // Saturate rather than wrap when nobody is waiting.
        if (keep_burst) begin
          if (!cnt_last) begin
            burst_cnt <= burst_cnt + BCW'(1);
          end
        end else begin
          burst_cnt <= '0;
        end
        if (switch_now) begin
          state       <= own_state(~cur_port);
          last_served <= cur_port;
        end else if (!accept) begin
          state <= ST_IDLE;
        end
      end
    end
  end

  always_comb begin
    owner_o = OWNER_NONE;
    if (own_a) begin
      owner_o = OWNER_A;
    end else if (own_b) begin
      owner_o = OWNER_B;
    end
  end

  assign rdata_a_o = ram_q_i;
  assign rdata_b_o = ram_q_i;

  blockram_arb_rtag #(
    .RD_LAT(RD_LAT)
  ) u_rtag (
    .clk_i     (clk_i),
    .areset_n_i(areset_n_i),
    .push_i    (accept & ~cur_we),
    .port_i    (cur_port),
    .rvalid_a_o(rvalid_a_o),
    .rvalid_b_o(rvalid_b_o)
  );

endmodule

// File: doc/blockram_arbiter.md
Name: blockram_arbiter

Overview:
- Two-requester arbiter for the single-port 8-bit SD-card buffer block RAM.
- Port A is the CPU-facing spooler. Port B is the SD card controller DMA side.
- Grants are round-robin, with optional locked bursts and a bounded burst length. Read data is tagged back to the issuing port.
- Sits between both requesters and the block RAM address/data/wren/q pins.

Parameters:
- AW, 16, address width
- DW, 8, data width
- RD_LAT, 2, clock edges from the accept edge to the cycle in which ram_q_i holds the read data (≥1)
- BURST_MAX, 16, maximum consecutive locked transactions while the other port waits (≥1)

Ports:
- clk_i  in  1  system clock
- areset_n_i  in  1  asynchronous reset, active low
- req_a_i / req_b_i  in  1  transaction request
- lock_a_i / lock_b_i  in  1  hold grant for burst
- we_a_i / we_b_i  in  1  1=write, 0=read
- addr_a_i / addr_b_i  in  AW  address
- wdata_a_i / wdata_b_i  in  DW  write data
- ack_a_o / ack_b_o  out  1  combinational; transaction accepted on this edge
- rdata_a_o / rdata_b_o  out  DW  read data (pass-through of ram_q_i)
- rvalid_a_o / rvalid_b_o  out  1  read data valid, one cycle per read
- ram_address_o  out  AW  registered RAM address
- ram_data_o  out  DW  registered RAM write data
- ram_wren_o  out  1  registered RAM write enable
- ram_q_i  in  DW  RAM read data
- owner_o  out  2  00 idle, 01 A, 10 B

Behaviour:
- Reset (async on areset_n_i low):
  - state=IDLE, last_served=B so A wins the first tie, burst_cnt=0.
  - ram_address_o=0, ram_data_o=0, ram_wren_o=0, owner_o=00.
  - Read-tag pipeline cleared, so rvalid_*=0 and no spurious rvalid after reset.
- States IDLE, OWN_A, OWN_B. owner_o mirrors state.
- ack_x_o = (state==OWN_x) & req_x_i & ~areset. No transaction is accepted in IDLE.
- IDLE arbitration (1-cycle grant latency):
  - Only req_a → OWN_A. Only req_b → OWN_B.
  - Both → the port ≠ last_served. Neither → stay.
- Accept edge (OWN_x & req_x):
  - ram_address_o<=addr_x, ram_data_o<=wdata_x, ram_wren_o<=we_x.
  - A read pushes tag {1, x} into the RD_LAT-deep delay line.
  - burst_cnt<=burst_cnt+1.
- Non-accept edges: ram_wren_o<=0; address and data hold.
- Release condition on an accept edge: ~lock_x, or (burst_cnt==BURST_MAX-1 & req_other).
  - On release with req_other: → OWN_other, last_served<=x, burst_cnt<=0.
  - On release with no req_other: park in OWN_x, burst_cnt<=0. Back-to-back unlocked single-requester traffic runs at 1/cycle.
- OWN_x with ~req_x:
  - req_other → OWN_other, last_served<=x, burst_cnt<=0.
  - Otherwise → IDLE.
- Grant and lock apply only to the owner. lock on the non-owner is ignored until it owns.
- Read return:
  - rvalid_x_o=1 for exactly one cycle, RD_LAT edges after the accept edge, when the tag at the line output is {1, x}.
  - rdata_a_o = rdata_b_o = ram_q_i always; consumers qualify with rvalid.
  - Writes produce no rvalid.
  - Tags survive grant changes, so A's read data still returns to A after the grant moves to B.
- Simultaneous events:
  - A release edge with req_other high switches owner with no idle cycle. The other port's first ack comes the next cycle.
  - A requester dropping req at the same edge as a release behaves as a release.
- Width rules:
  - burst_cnt is ceil(log2(BURST_MAX+1)) bits; it never exceeds BURST_MAX-1 while the other port waits.
  - When unopposed, burst_cnt saturates at BURST_MAX-1 and does not wrap.
  - Address pass-through is unmodified; no address wrap logic.

Decomposition:
- Package blockram_arb_pkg: state encoding (IDLE=2'd0, OWN_A=2'd1, OWN_B=2'd2), owner codes, PORT_A/PORT_B tag constants.
- Sub-module blockram_arb_rtag: RD_LAT-deep shift register of {valid, port}.
  - Async active-low clear.
  - Outputs rvalid_a/rvalid_b.

Test Plan:
- Reset then req_a=1, we=0, addr=16'h0010, lock=0 for 4 cycles:
  - ack_a low in cycle 0 (IDLE), then high cycles 1–3.
  - ram_address_o = 0010 after each accept.
  - rvalid_a pulses 3 times, each RD_LAT=2 edges after its accept; rvalid_b stays 0.
- Both req_a and req_b asserted from IDLE, lock=0, addresses 0100/0200:
  - Grants alternate A, B, A, B…
  - ram_address_o alternates 0100/0200 on consecutive edges.
- A locked with continuous req, B requesting with BURST_MAX=4:
  - Exactly 4 consecutive A accepts, then the grant switches to B with no idle cycle.
- B locked with continuous req, A idle:
  - B accepts 20 consecutive transactions with no grant change; burst_cnt saturates at BURST_MAX-1 (3) and does not wrap.
- A read at addr 0005 accepted on the edge of its final request, with the grant passing to B (write 8'hA5 to 0006) on that same edge:
  - rvalid_a returns 2 edges after A's accept; rvalid_b never asserts.
  - ram_wren_o high for exactly one cycle with ram_data_o=A5.
- areset_n_i pulsed low 1 cycle after a read accept:
  - All outputs return to reset values immediately.
  - No rvalid occurs; the next IDLE tie goes to A.
